vc_link_arbiter6: RTL and testbench

Packet-level round-robin arbiter that shares one output link between six virtual-channel buffers in the router output port. It picks an eligible VC, holds the grant until that VC's tail flit crosses the link, and tracks downstream buffer credits per VC. It drives the 3-bit VC select code consumed by the six-way VC enable decoder, plus a one-hot grant for local use.

---
 rtl/vca_pkg.sv | 46 ++++
 rtl/rr_pick6.sv | 30 +++
 rtl/vc_link_arbiter6.sv | 150 +++++++++++++++
 tb/tb_vc_link_arbiter6.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vca_pkg.sv
// Shared constants, state type and select-code mapping for the six-VC link arbiter.
package vca_pkg;

    localparam int NUM_VC         = 6;
    localparam int CREDIT_MAX_DEF = 4;
    localparam int CREDIT_W_DEF   = 3;

    localparam logic [2:0] SEL_VC0  = 3'b000;
    localparam logic [2:0] SEL_VC1  = 3'b001;
    localparam logic [2:0] SEL_VC2  = 3'b011;
    localparam logic [2:0] SEL_VC3  = 3'b010;
    localparam logic [2:0] SEL_VC4  = 3'b110;
    localparam logic [2:0] SEL_VC5  = 3'b100;
    localparam logic [2:0] SEL_IDLE = 3'b111;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [2:0] vc_to_sel(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = SEL_VC0;
            3'd1:    code = SEL_VC1;
            3'd2:    code = SEL_VC2;
            3'd3:    code = SEL_VC3;
            3'd4:    code = SEL_VC4;
            3'd5:    code = SEL_VC5;
            default: code = SEL_IDLE;
        endcase
        return code;
    endfunction

    // Reduce a sum of two VC indices (0..10) back into 0..5.
    function automatic logic [2:0] vc_wrap(input logic [3:0] v);
        logic [2:0] r;
        if (v >= 4'd6) begin
            r = 3'(v - 4'd6);
        end else begin
            r = v[2:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin picker: first set bit of eligible scanning from rr_ptr, wrapping at 6.
module rr_pick6
    import vca_pkg::*;
(
    input  logic [5:0] eligible,
    input  logic [2:0] rr_ptr,
    output logic       valid,
    output logic [2:0] idx
);

    logic [2:0] cand_s;

    // Scan from farthest to nearest so the candidate closest to rr_ptr wins.
    always_comb begin
        valid  = 1'b0;
        idx    = 3'd0;
        cand_s = 3'd0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            cand_s = vc_wrap({1'b0, rr_ptr} + 4'(k));
            if (eligible[cand_s]) begin
                valid = 1'b1;
                idx   = cand_s;
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/vc_link_arbiter6.sv
// Packet-locking round-robin arbiter sharing one link among six VCs.
// Optional downstream credit tracking is built when VCA_CREDIT_EN is defined.
module vc_link_arbiter6
    import vca_pkg::*;
#(
    parameter int CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int CREDIT_W   = CREDIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_VC-1:0] req,
    input  logic [NUM_VC-1:0] tail,
    input  logic [NUM_VC-1:0] credit_ret,
    input  logic              link_ready,
    output logic [NUM_VC-1:0] grant,
    output logic [2:0]        sel_addr,
    output logic              flit_valid,
    output logic              busy,
    output logic              err_ovf
);

    state_t            state_r, state_n;
    logic [2:0]        owner_r, owner_n;
    logic [2:0]        rr_ptr_r, rr_ptr_n;
    logic [NUM_VC-1:0] credit_ok_s;
    logic [NUM_VC-1:0] eligible_s;
    logic              pick_valid_s;
    logic [2:0]        pick_idx_s;

    assign eligible_s = req & credit_ok_s;
    assign flit_valid = (state_r == ST_LOCKED) && req[owner_r] && credit_ok_s[owner_r] && link_ready;

    rr_pick6 u_pick (
        .eligible (eligible_s),
        .rr_ptr   (rr_ptr_r),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s)
    );

    // Arbitration state, owner and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= 3'd0;
            rr_ptr_r <= 3'd0;
        end else begin
            state_r  <= state_n;
            owner_r  <= owner_n;
            rr_ptr_r <= rr_ptr_n;
        end
    end

    // Lock on a pick; release only after the tail flit crosses.
    always_comb begin
        state_n  = state_r;
        owner_n  = owner_r;
        rr_ptr_n = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_n = ST_LOCKED;
                    owner_n = pick_idx_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (flit_valid && tail[owner_r]) begin
                    state_n  = ST_IDLE;
                    rr_ptr_n = vc_wrap({1'b0, owner_r} + 4'd1);
                end else begin
                    state_n = ST_LOCKED;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and owner only.
    always_comb begin
        grant    = {NUM_VC{1'b0}};
        sel_addr = SEL_IDLE;
        busy     = 1'b0;
        case (state_r)
            ST_LOCKED: begin
                grant    = 6'b000001 << owner_r;
                sel_addr = vc_to_sel(owner_r);
                busy     = 1'b1;
            end
            default: begin
                grant    = {NUM_VC{1'b0}};
                sel_addr = SEL_IDLE;
                busy     = 1'b0;
            end
        endcase
    end

`ifdef VCA_CREDIT_EN
    logic [NUM_VC-1:0] ovf_s;
    logic              err_ovf_r;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_credit
        logic [CREDIT_W-1:0] cnt_r;
        logic                dec_s;
        logic                at_max_s;

        assign dec_s          = flit_valid && (owner_r == 3'(i));
        assign at_max_s       = (cnt_r == CREDIT_W'(CREDIT_MAX));
        assign credit_ok_s[i] = (cnt_r != {CREDIT_W{1'b0}});
        assign ovf_s[i]       = credit_ret[i] && at_max_s;

        // Per-VC credit counter; simultaneous send and return cancel out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= CREDIT_W'(CREDIT_MAX);
            end else if (credit_ret[i] && !dec_s && !at_max_s) begin
                cnt_r <= cnt_r + {{(CREDIT_W-1){1'b0}}, 1'b1};
            end else if (dec_s && !credit_ret[i]) begin
                cnt_r <= cnt_r - {{(CREDIT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_r <= 1'b0;
        end else if (|ovf_s) begin
            err_ovf_r <= 1'b1;
        end else begin
            err_ovf_r <= err_ovf_r;
        end
    end

    assign err_ovf = err_ovf_r;
`else
    logic [NUM_VC-1:0]   unused_ret_s;
    logic [CREDIT_W-1:0] unused_cap_s;

    assign unused_ret_s = credit_ret;
    assign unused_cap_s = CREDIT_W'(CREDIT_MAX);
    assign credit_ok_s  = {NUM_VC{1'b1}};
    assign err_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_vc_link_arbiter6.sv
// Self-checking bench for vc_link_arbiter6: directed scenarios plus random traffic vs. a packet-level model.
module tb_vc_link_arbiter6;

    localparam int CMAX = 4;
    localparam logic [2:0] SEL_TAB [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] req, tail, credit_ret;
    logic       link_ready;
    logic [5:0] grant;
    logic [2:0] sel_addr;
    logic       flit_valid, busy, err_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: owner index (-1 = idle), pointer, credits, sticky error
    int m_owner;
    int m_ptr;
    int m_credit [6];
    bit m_err;

    vc_link_arbiter6 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .tail       (tail),
        .credit_ret (credit_ret),
        .link_ready (link_ready),
        .grant      (grant),
        .sel_addr   (sel_addr),
        .flit_valid (flit_valid),
        .busy       (busy),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit ok(input int i);
`ifdef VCA_CREDIT_EN
        return m_credit[i] != 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit exp_fv();
        if (m_owner < 0) return 1'b0;
        return req[m_owner] && ok(m_owner) && link_ready;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_err   = 1'b0;
        for (int i = 0; i < 6; i++) m_credit[i] = CMAX;
    endtask

    task automatic model_step();
        bit fv;
        int cur;
        int pick;
        fv  = exp_fv();
        cur = m_owner;
        if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < 6; k++) begin
                int c;
                c = (m_ptr + k) % 6;
                if (pick < 0 && req[c] && ok(c)) pick = c;
            end
            m_owner = pick;
        end else if (fv && tail[m_owner]) begin
            m_ptr   = (m_owner + 1) % 6;
            m_owner = -1;
        end
`ifdef VCA_CREDIT_EN
        for (int i = 0; i < 6; i++) begin
            bit dec;
            dec = fv && (cur == i);
            if (credit_ret[i] && m_credit[i] == CMAX) m_err = 1'b1;
            if (credit_ret[i] && !dec) m_credit[i] = (m_credit[i] < CMAX) ? m_credit[i] + 1 : CMAX;
            else if (dec && !credit_ret[i]) m_credit[i] = m_credit[i] - 1;
        end
`endif
    endtask

    // Compare every output with the model, then advance one clock.
    task automatic tick();
        logic [5:0] eg;
        logic [2:0] es;
        #1;
        eg = (m_owner < 0) ? 6'b000000 : (6'b000001 << m_owner);
        es = (m_owner < 0) ? 3'b111 : SEL_TAB[m_owner];
        chk("grant", 8'(grant), 8'(eg));
        chk("sel_addr", 8'(sel_addr), 8'(es));
        chk("busy", 8'(busy), 8'(m_owner >= 0));
        chk("flit_valid", 8'(flit_valid), 8'(exp_fv()));
        chk("err_ovf", 8'(err_ovf), 8'(m_err));
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [5:0] g, input logic [2:0] s,
                              input logic b, input logic f);
        #1;
        chk({tag, "_grant"}, 8'(grant), 8'(g));
        chk({tag, "_sel"}, 8'(sel_addr), 8'(s));
        chk({tag, "_busy"}, 8'(busy), 8'(b));
        chk({tag, "_fv"}, 8'(flit_valid), 8'(f));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; tail = '0; credit_ret = '0; link_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        expect_out("reset", 6'b000000, 3'b111, 1'b0, 1'b0);
        chk("reset_err", 8'(err_ovf), 8'd0);
        rst_n = 1'b1;

        // single-flit packet on VC0
        req = 6'b000001; tail = 6'b111111; link_ready = 1'b1;
        tick();
        expect_out("t1_gnt", 6'b000001, 3'b000, 1'b1, 1'b1);
        tick();
        req = 6'b000000;
        expect_out("t1_idle", 6'b000000, 3'b111, 1'b0, 1'b0);
        tick();

        // all VCs requesting single-flit packets: full rotation with bubbles
        do_reset();
        req = 6'b111111; tail = 6'b111111;
        for (int k = 0; k < 7; k++) begin
            tick();
            expect_out("t2_rot", 6'b000001 << (k % 6), SEL_TAB[k % 6], 1'b1, 1'b1);
            tick();
        end

        // VC2 4-flit packet with a 2-cycle req drop; VC5 waits
        do_reset();
        req = 6'b000100; tail = 6'b000000;
        tick();
        req = 6'b100100;
        tick(); tick();
        req = 6'b100000;
        expect_out("t3_stall", 6'b000100, 3'b011, 1'b1, 1'b0);
        tick();
        expect_out("t3_stall", 6'b000100, 3'b011, 1'b1, 1'b0);
        tick();
        req = 6'b100100;
        tick();
        tail = 6'b000100;
        tick();
        tail = 6'b000000;
        expect_out("t3_gap", 6'b000000, 3'b111, 1'b0, 1'b0);
        tick();
        expect_out("t3_vc5", 6'b100000, 3'b100, 1'b1, 1'b1);
        tick();

`ifdef VCA_CREDIT_EN
        // VC1 runs out of credit mid-packet
        do_reset();
        req = 6'b000010; tail = 6'b000000;
        tick();
        repeat (4) tick();
        expect_out("t4_dry", 6'b000010, 3'b001, 1'b1, 1'b0);
        tick();
        credit_ret = 6'b000010;
        tick();
        credit_ret = 6'b000000;
        expect_out("t4_one", 6'b000010, 3'b001, 1'b1, 1'b1);
        tick();
        expect_out("t4_dry2", 6'b000010, 3'b001, 1'b1, 1'b0);
        tick();
        credit_ret = 6'b000010;
        tick();
        expect_out("t4_same", 6'b000010, 3'b001, 1'b1, 1'b1);
        tick();
        credit_ret = 6'b000000; tail = 6'b000010;
        expect_out("t4_kept", 6'b000010, 3'b001, 1'b1, 1'b1);
        tick();
        // overflow on VC3 at full credit, counter must stay at 4
        req = 6'b000000; tail = 6'b000000; credit_ret = 6'b001000;
        tick();
        credit_ret = 6'b000000;
        #1 chk("t5_err", 8'(err_ovf), 8'd1);
        req = 6'b001000;
        tick();
        repeat (4) tick();
        expect_out("t5_sat", 6'b001000, 3'b010, 1'b1, 1'b0);
        tick();
`endif

        // asynchronous reset during a VC4 packet
        do_reset();
        req = 6'b010000; tail = 6'b000000;
        tick(); tick();
        #2 rst_n = 1'b0;
        expect_out("t6_rst", 6'b000000, 3'b111, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; req = 6'b111111; tail = 6'b111111;
        tick();
        expect_out("t6_vc0", 6'b000001, 3'b000, 1'b1, 1'b1);
        tick();

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            req        = 6'($urandom);
            tail       = 6'($urandom) & 6'($urandom);
            link_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 6; i++)
                credit_ret[i] = (m_credit[i] < CMAX) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
